ps2_byte_rx: RTL and testbench
==============================

Name: ps2_byte_rx

Overview:
- Upstream stage of the PS/2 mouse packet framer.
- Deserialises the raw PS/2 device clock/data lines into bytes and presents each byte with a one-cycle valid pulse; the framer consumes it as its 8-bit input plus enable.
- Synchronises the line inputs, filters them for glitches, detects PS/2 clock falling edges, checks start, odd parity and stop bits, and aborts stalled frames on timeout.

Parameters:
- FILTER_LEN, 4, consecutive identical synchronised samples required before a filtered line changes; range 2..16.
- TIMEOUT_CYCLES, 2000, system clocks with no filtered PS/2 clock falling edge before a partial frame is abandoned.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- ps2_clk_in  input  1  raw PS/2 clock line, asynchronous to clk.
- ps2_data_in  input  1  raw PS/2 data line, asynchronous to clk.
- byte_out  output  8  last received byte; holds until the next accepted byte.
- byte_valid  output  1  one-cycle pulse; byte_out is good in that cycle.
- parity_err  output  1  one-cycle pulse; frame dropped on bad parity.
- frame_err  output  1  one-cycle pulse; bad stop bit or timeout; frame dropped.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset:
  - Asynchronous assert: byte_out=0x00; byte_valid, parity_err and frame_err low; busy=0; state=IDLE.
  - Synchroniser flops reset to 1 and filtered lines reset to 1 (bus idle high).
  - Timeout counter cleared; shift register cleared.
- Input path (each line):
  - 2-flop synchroniser, then a filter. The filtered value updates to the synchronised value once FILTER_LEN consecutive synchronised samples agree and differ from the current filtered value.
  - A falling edge ("fall") is a registered 1-cycle strobe generated when the filtered clock goes 1->0.
  - Data is sampled from the filtered data line in the fall cycle.
- Frame format: start(0), D0..D7 LSB first, odd parity (total ones over D0..D7 plus parity bit is odd), stop(1).
- State machine, advancing on fall unless noted:
  - IDLE: if sampled data=0, go to DATA with bit count=0. If sampled data=1, stay in IDLE; this is a spurious edge and raises no error.
  - DATA: shift the sample into bit[count], count++. After the 8th bit go to PARITY.
  - PARITY: store the sampled parity bit and go to STOP.
  - STOP:
    - If sample=1 and parity is good: byte_out<=data, byte_valid pulses.
    - If sample=1 and parity is bad: parity_err pulses; byte_out is unchanged.
    - If sample=0: frame_err pulses, even if parity is also bad; frame_err has priority and parity_err stays low.
    - In all cases return to IDLE.
- Latency: the status pulse (byte_valid, parity_err or frame_err) is asserted in the cycle after the fall cycle of the stop bit.
  - Never more than one status pulse per frame.
  - Pulses are exactly one cycle wide.
- Timeout:
  - The counter clears on every fall and while in IDLE; otherwise it increments in DATA, PARITY and STOP.
  - When it reaches TIMEOUT_CYCLES-1: frame_err pulses for one cycle, state goes to IDLE, and the partial data is discarded.
  - The counter saturates (no wrap) and is cleared on entry to IDLE.
  - If a fall and the timeout occur in the same cycle, the fall wins and the counter clears.
- Back-to-back frames: the start bit of the next frame may arrive on the fall immediately after the stop bit. IDLE accepts it with no lost bit.
- Reset mid-frame: everything returns to reset values immediately and no status pulse is emitted. After deassertion the receiver waits in IDLE for a fresh start bit.
- Glitches: any pulse on either line shorter than FILTER_LEN cycles must not generate a fall and must not change sampled data.

Test Plan:
- Frame 0x5A, parity 1, stop 1, at 40 clk/bit, FILTER_LEN=4 -> byte_out=0x5A and one byte_valid pulse one cycle after the stop fall; parity_err=0, frame_err=0.
- Byte 0x08 sent with parity 1 (wrong; correct is 0) -> parity_err pulses once, byte_valid stays 0, byte_out keeps its previous value 0x5A.
- Frame 0xFF with parity 1 but stop bit 0 -> frame_err pulses once, parity_err=0, byte_valid=0.
- TIMEOUT_CYCLES=200: send start plus 3 data bits, then hold the clock high -> frame_err pulses 200 cycles after the last fall, busy drops. A following valid 0x08 frame (parity 0) then yields byte_valid with byte_out=0x08.
- 3-cycle low glitch on ps2_clk_in while idle, and a 2-cycle glitch on ps2_data_in mid-bit -> no fall is generated and no data corruption; frame 0x5A is still received correctly.
- Assert reset_n=0 for 2 cycles after the 5th data bit of frame 0xA5 -> all outputs 0 immediately and no status pulse. The next full 0xA5 frame (parity 1) gives byte_valid with 0xA5.

Source files
------------

// File: rtl/ps2_byte_rx_if.sv
// ps2_byte_rx_if: raw PS/2 lines in, received byte and status pulses out
interface ps2_byte_rx_if;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    modport master (output ps2_clk_in, ps2_data_in, input byte_out, byte_valid, parity_err, frame_err, busy);
    modport slave  (input ps2_clk_in, ps2_data_in, output byte_out, byte_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/ps2_byte_rx.sv
// ps2_byte_rx: PS/2 line deserialiser with glitch filter, parity/stop checks and frame timeout
module ps2_byte_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input logic          clk,
    input logic          reset_n,
    ps2_byte_rx_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0] FL_M1 = 5'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_M1 = TW'(TIMEOUT_CYCLES - 1);
    logic [1:0]    sync1_q, sync2_q, filt_q, filt_d;
    logic [4:0]    fcnt_q [2];
    logic [4:0]    fcnt_d [2];
    logic          fall_q;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d, byte_q, byte_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic          sample;
    // index 0 is the clock line, index 1 the data line
    for (genvar i = 0; i < 2; i++) begin : g_filt
        assign fcnt_d[i] = (sync2_q[i] == filt_q[i] || fcnt_q[i] == FL_M1) ? 5'd0 : fcnt_q[i] + 5'd1;
        assign filt_d[i] = (sync2_q[i] != filt_q[i] && fcnt_q[i] == FL_M1) ? sync2_q[i] : filt_q[i];
    end
    assign sample = filt_q[1];
    // synchronise, filter and strobe filtered clock falling edges; lines idle high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            fcnt_q  <= '{default: 5'd0};
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= {bus.ps2_data_in, bus.ps2_clk_in};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            fall_q  <= filt_q[0] & ~filt_d[0];
        end
    end
    // frame state machine; a fall always beats a coincident timeout
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        byte_d  = byte_q;
        tmo_d   = '0;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (fall_q) begin
            case (state_q)
                IDLE: begin
                    state_d = sample ? IDLE : DATA;
                    bcnt_d  = 3'd0;
                end
                DATA: begin
                    shift_d[bcnt_q] = sample;
                    bcnt_d          = bcnt_q + 3'd1;
                    state_d         = (bcnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = sample;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    ferr_d  = ~sample;
                    valid_d = sample & (^{shift_q, par_q});
                    perr_d  = sample & ~(^{shift_q, par_q});
                    byte_d  = valid_d ? shift_q : byte_q;
                end
            endcase
        end else if (state_q != IDLE) begin
            ferr_d  = (tmo_q == T_M1);
            state_d = ferr_d ? IDLE : state_q;
            tmo_d   = ferr_d ? '0 : tmo_q + TW'(1);
        end
    end
    // frame state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bcnt_q  <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            byte_q  <= 8'h00;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            byte_q  <= byte_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end
    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_byte_rx.sv
// tb_ps2_byte_rx: table-driven frames plus timeout, glitch and reset sequences, scoreboarded status pulses
module tb_ps2_byte_rx;
    localparam int HALF = 20;
    localparam int LAT  = 7;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   cyc = 0;
    int   last_fall = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ps2_byte_rx_if bus ();
    ps2_byte_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        int         gap;
        logic [2:0] kind;
        logic [7:0] bo;
    } vec_t;
    typedef struct {
        logic [2:0] kind;
        logic [7:0] bo;
        int         lo;
        int         hi;
    } exp_t;
    exp_t q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send_bit(input logic b, input logic g);
        bus.ps2_data_in = b;
        if (g) begin
            repeat (5) tick();
            bus.ps2_data_in = ~b;
            repeat (2) tick();
            bus.ps2_data_in = b;
            repeat (HALF - 7) tick();
        end else begin
            repeat (HALF) tick();
        end
        bus.ps2_clk_in = 1'b0;
        last_fall = cyc;
        repeat (HALF) tick();
        bus.ps2_clk_in = 1'b1;
    endtask
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic [2:0] kind, input logic [7:0] bo, input int gb);
        exp_t e;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == gb);
        send_bit(p, 1'b0);
        e = '{kind, bo, cyc + HALF + LAT, cyc + HALF + LAT};
        q.push_back(e);
        send_bit(s, 1'b0);
        bus.ps2_data_in = 1'b1;
    endtask
    // scoreboard: every status pulse must match the oldest expectation
    always @(negedge clk) begin
        logic [2:0] pulses;
        exp_t e;
        pulses = {bus.byte_valid, bus.parity_err, bus.frame_err};
        if (reset_n && pulses != 3'b000) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {29'd0, pulses}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {29'd0, pulses}, {29'd0, e.kind});
                check("byte_out", {24'd0, bus.byte_out}, {24'd0, e.bo});
                n_tests++;
                if (cyc < e.lo || cyc > e.hi) begin
                    n_fail++;
                    $display("FAIL pulse_cycle: got %0d expected %0d..%0d", cyc, e.lo, e.hi);
                end
            end
        end
    end
    initial begin
        vec_t vt[8];
        exp_t e;
        vt[0] = '{8'h5A, 1'b1, 1'b1, 30, 3'b100, 8'h5A};
        vt[1] = '{8'h08, 1'b1, 1'b1, 30, 3'b010, 8'h5A};
        vt[2] = '{8'hFF, 1'b1, 1'b0, 30, 3'b001, 8'h5A};
        vt[3] = '{8'h00, 1'b1, 1'b1, 0,  3'b100, 8'h00};
        vt[4] = '{8'hC3, 1'b1, 1'b1, 0,  3'b100, 8'hC3};
        vt[5] = '{8'h80, 1'b0, 1'b1, 30, 3'b100, 8'h80};
        vt[6] = '{8'h7E, 1'b1, 1'b0, 30, 3'b001, 8'h80};
        vt[7] = '{8'h01, 1'b1, 1'b1, 30, 3'b010, 8'h80};
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_byte_out", {24'd0, bus.byte_out}, 32'h0);
        check("rst_pulses", {29'd0, bus.byte_valid, bus.parity_err, bus.frame_err}, 32'h0);
        check("rst_busy", {31'd0, bus.busy}, 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            send_frame(vt[i].d, vt[i].p, vt[i].s, vt[i].kind, vt[i].bo, -1);
            repeat (vt[i].gap) tick();
        end
        repeat (30) tick();
        check("table_drain", q.size(), 32'd0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        bus.ps2_data_in = 1'b1;
        e = '{3'b001, 8'h80, last_fall + 200, last_fall + 210};
        q.push_back(e);
        repeat (60) tick();
        check("tmo_busy_before", {31'd0, bus.busy}, 32'd1);
        repeat (180) tick();
        check("tmo_busy_after", {31'd0, bus.busy}, 32'd0);
        check("tmo_drain", q.size(), 32'd0);
        send_frame(8'h08, 1'b0, 1'b1, 3'b100, 8'h08, -1);
        repeat (30) tick();
        bus.ps2_data_in = 1'b0;
        repeat (10) tick();
        bus.ps2_clk_in = 1'b0;
        repeat (3) tick();
        bus.ps2_clk_in = 1'b1;
        repeat (15) tick();
        check("glitch_busy", {31'd0, bus.busy}, 32'd0);
        bus.ps2_data_in = 1'b1;
        repeat (20) tick();
        send_frame(8'h5A, 1'b1, 1'b1, 3'b100, 8'h5A, 3);
        repeat (30) tick();
        check("glitch_drain", q.size(), 32'd0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_byte_out", {24'd0, bus.byte_out}, 32'h0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'h0);
        check("mid_rst_pulses", {29'd0, bus.byte_valid, bus.parity_err, bus.frame_err}, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        bus.ps2_data_in = 1'b1;
        repeat (40) tick();
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("post_rst_drain", q.size(), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b1, 3'b100, 8'hA5, -1);
        repeat (30) tick();
        check("final_drain", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
